// File: rtl/qam_mod_param.sv
// rtl/qam_mod_param.sv - byte-stream to Gray-mapped QPSK/16-QAM/64-QAM I/Q symbol modulator
module qam_mod_param #(
    parameter int         OUT_W    = 8,
    parameter logic [1:0] MODE_RST = 2'd1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              mode,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic signed [OUT_W-1:0] I_out,
    output logic signed [OUT_W-1:0] Q_out,
    output logic                    out_valid,
    output logic                    out_last,
    input  logic                    out_ready
);

    // Oldest bit sits at r_buf[15]; bits below the valid count are always zero,
    // which makes the tail padding of a burst free.
    logic [15:0] r_buf;
    logic [4:0]  r_cnt;
    logic        r_last_pending;
    logic [1:0]  r_mode;

    logic [4:0]  w_bps;
    logic [1:0]  w_k;
    logic        w_slot_free;
    logic        w_accept;
    logic        w_form;
    logic        w_sym_last;
    logic [4:0]  w_cnt_after;
    logic [4:0]  w_cnt_next;
    logic [15:0] w_buf_after;
    logic [15:0] w_buf_next;
    logic [2:0]  w_gi;
    logic [2:0]  w_gq;

    function automatic logic signed [OUT_W-1:0] map_axis(input logic [2:0] g, input logic [1:0] k);
        logic [2:0] b;
        int         lv;
        // Leading zeros of a narrower code leave its Gray decode unchanged.
        b[2] = g[2];
        b[1] = g[2] ^ g[1];
        b[0] = g[2] ^ g[1] ^ g[0];
        lv   = 2 * int'(b) - ((1 << k) - 1);
        return OUT_W'(lv);
    endfunction

    always_comb begin
        w_bps = 5'd4;
        w_k   = 2'd2;
        case (r_mode)
            2'd0: begin w_bps = 5'd2; w_k = 2'd1; end
            2'd2: begin w_bps = 5'd6; w_k = 2'd3; end
            default: begin w_bps = 5'd4; w_k = 2'd2; end
        endcase
    end

    always_comb begin
        w_gi = {1'b0, r_buf[15:14]};
        w_gq = {1'b0, r_buf[13:12]};
        case (w_k)
            2'd1: begin w_gi = {2'b00, r_buf[15]}; w_gq = {2'b00, r_buf[14]}; end
            2'd3: begin w_gi = r_buf[15:13];       w_gq = r_buf[12:10];       end
            default: begin w_gi = {1'b0, r_buf[15:14]}; w_gq = {1'b0, r_buf[13:12]}; end
        endcase
    end

    assign in_ready    = (r_cnt <= 5'd8) && !r_last_pending;
    assign w_accept    = in_valid && in_ready;
    assign w_slot_free = !out_valid || out_ready;
    assign w_form      = w_slot_free && ((r_cnt >= w_bps) || (r_last_pending && (r_cnt != 5'd0)));
    assign w_sym_last  = r_last_pending && (r_cnt <= w_bps);

    // Consume first, then append, so a symbol never sees the byte arriving with it.
    always_comb begin
        w_cnt_after = r_cnt;
        w_buf_after = r_buf;
        if (w_form) begin
            w_cnt_after = (r_cnt >= w_bps) ? (r_cnt - w_bps) : 5'd0;
            w_buf_after = r_buf << w_bps;
        end
        w_cnt_next = w_cnt_after;
        w_buf_next = w_buf_after;
        if (w_accept) begin
            w_cnt_next = w_cnt_after + 5'd8;
            w_buf_next = w_buf_after | ({in_data, 8'h00} >> w_cnt_after);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf          <= 16'h0000;
            r_cnt          <= 5'd0;
            r_last_pending <= 1'b0;
            r_mode         <= MODE_RST;
            I_out          <= '0;
            Q_out          <= '0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
        end else begin
            r_buf <= w_buf_next;
            r_cnt <= w_cnt_next;
            if (r_cnt == 5'd0 && !r_last_pending) begin
                r_mode <= mode;
            end
            if (w_form && w_sym_last) begin
                r_last_pending <= 1'b0;
            end else if (w_accept && in_last) begin
                r_last_pending <= 1'b1;
            end
            if (w_form) begin
                I_out     <= map_axis(w_gi, w_k);
                Q_out     <= map_axis(w_gq, w_k);
                out_valid <= 1'b1;
                out_last  <= w_sym_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_qam_mod_param.sv
// tb/tb_qam_mod_param.sv - directed self-checking bench for qam_mod_param
module tb_qam_mod_param;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        mode;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic signed [7:0] I_out;
    logic signed [7:0] Q_out;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_wait;
    int max_wait;
    int base;

    logic signed [7:0] qi[$];
    logic signed [7:0] qq[$];
    logic              ql[$];
    int                qt[$];

    logic signed [7:0] hold_i;
    logic signed [7:0] hold_q;

    qam_mod_param #(.OUT_W(8), .MODE_RST(2'd1)) dut (
        .clk(clk), .reset(reset), .mode(mode),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .I_out(I_out), .Q_out(Q_out), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transfers are decided at the next rising edge; capture them mid-cycle.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            qi.push_back(I_out);
            qq.push_back(Q_out);
            ql.push_back(out_last);
            qt.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
        end
        last_wait = n;
        if (n >= 50) chk("send_timeout", n, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_syms(input string tag, input int n);
        for (int c = 0; c < 200 && qi.size() < n; c++) @(posedge clk);
        #1;
        chk(tag, qi.size(), n);
    endtask

    task automatic chk_sym(input string tag, input int idx, input int ei, input int eq, input logic el);
        if (idx < qi.size()) begin
            chk({tag, "_I"}, qi[idx], ei);
            chk({tag, "_Q"}, qq[idx], eq);
            chk({tag, "_last"}, ql[idx], el);
        end else begin
            chk({tag, "_present"}, qi.size(), idx + 1);
        end
    endtask

    initial begin
        reset = 1'b1; mode = 2'd1; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_I", I_out, 0);
        chk("rst_Q", Q_out, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b0;

        // 16-QAM, 0xB4 with last
        base = qi.size();
        mode = 2'd1;
        send_byte(8'hB4, 1'b1);
        wait_syms("b4_count", base + 2);
        chk_sym("b4_s0", base, 3, 1, 1'b0);
        chk_sym("b4_s1", base + 1, -1, -3, 1'b1);
        if (qt.size() >= base + 2) chk("b4_consecutive", qt[base+1] - qt[base], 1);

        // 64-QAM, 0xFF with last and zero-padded tail
        base = qi.size();
        mode = 2'd2;
        send_byte(8'hFF, 1'b1);
        wait_syms("ff_count", base + 2);
        chk_sym("ff_s0", base, 3, 3, 1'b0);
        chk_sym("ff_s1", base + 1, 1, -7, 1'b1);

        // QPSK 0x1B without, then with, last
        base = qi.size();
        mode = 2'd0;
        send_byte(8'h1B, 1'b0);
        wait_syms("qpsk_count", base + 4);
        chk_sym("qpsk_s0", base, -1, -1, 1'b0);
        chk_sym("qpsk_s1", base + 1, -1, 1, 1'b0);
        chk_sym("qpsk_s2", base + 2, 1, -1, 1'b0);
        chk_sym("qpsk_s3", base + 3, 1, 1, 1'b0);
        base = qi.size();
        send_byte(8'h1B, 1'b1);
        wait_syms("qpskl_count", base + 4);
        chk_sym("qpskl_s2", base + 2, 1, -1, 1'b0);
        chk_sym("qpskl_s3", base + 3, 1, 1, 1'b1);

        // 64-QAM continuous 0x00,0xFF,0x00
        base = qi.size();
        mode = 2'd2;
        max_wait = 0;
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        if (last_wait > max_wait) max_wait = last_wait;
        send_byte(8'h00, 1'b1);
        if (last_wait > max_wait) max_wait = last_wait;
        chk("cont_max_wait_le1", (max_wait <= 1), 1);
        wait_syms("cont_count", base + 4);
        chk_sym("cont_s0", base, -7, -7, 1'b0);
        chk_sym("cont_s1", base + 1, -5, 3, 1'b0);
        chk_sym("cont_s2", base + 2, 3, 7, 1'b0);
        chk_sym("cont_s3", base + 3, -7, -7, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("cont_no_extra", qi.size(), base + 4);
        chk("cont_in_ready", in_ready, 1);

        // Backpressure: 16-QAM, two bytes, downstream stalled
        base = qi.size();
        mode = 2'd1;
        out_ready = 1'b0;
        send_byte(8'hB4, 1'b0);
        send_byte(8'h27, 1'b1);
        chk("bp_valid", out_valid, 1);
        chk("bp_in_ready_low", in_ready, 0);
        hold_i = I_out;
        hold_q = Q_out;
        chk("bp_I0", hold_i, 3);
        chk("bp_Q0", hold_q, 1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_I", I_out, hold_i);
            chk("bp_hold_Q", Q_out, hold_q);
            chk("bp_hold_last", out_last, 0);
            chk("bp_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        wait_syms("bp_count", base + 4);
        chk_sym("bp_s0", base, 3, 1, 1'b0);
        chk_sym("bp_s1", base + 1, -1, -3, 1'b0);
        chk_sym("bp_s2", base + 2, -3, 3, 1'b0);
        chk_sym("bp_s3", base + 3, -1, 1, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("bp_no_extra", qi.size(), base + 4);

        // Mode change mid-burst takes effect only after drain
        base = qi.size();
        mode = 2'd1;
        send_byte(8'hB4, 1'b0);
        mode = 2'd2;
        send_byte(8'h27, 1'b1);
        wait_syms("mc_count", base + 4);
        chk_sym("mc_s0", base, 3, 1, 1'b0);
        chk_sym("mc_s2", base + 2, -3, 3, 1'b0);
        chk_sym("mc_s3", base + 3, -1, 1, 1'b1);
        base = qi.size();
        send_byte(8'hFF, 1'b1);
        wait_syms("mc64_count", base + 2);
        chk_sym("mc64_s0", base, 3, 3, 1'b0);
        chk_sym("mc64_s1", base + 1, 1, -7, 1'b1);

        // Reset mid-burst discards everything
        base = qi.size();
        mode = 2'd1;
        out_ready = 1'b0;
        send_byte(8'hB4, 1'b0);
        @(posedge clk);
        #1;
        chk("mr_pre_valid", out_valid, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mr_valid", out_valid, 0);
        chk("mr_last", out_last, 0);
        chk("mr_in_ready", in_ready, 1);
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("mr_no_leftover", qi.size(), base);
        send_byte(8'hB4, 1'b1);
        wait_syms("mr_after_count", base + 2);
        chk_sym("mr_after_s0", base, 3, 1, 1'b0);
        chk_sym("mr_after_s1", base + 1, -1, -3, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
